pwm_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-channel 8-bit PWM.
- Drives NUM_CH independent PWM outputs from one shared period counter.
- Supports edge-aligned (sawtooth) and center-aligned (triangle) counting.
- Per-channel duty is double-buffered: host writes land in a pending register and are applied only at a period boundary, with a programmable right-shift attenuation. Sits between the DSP/control path and the output pins.

---
 rtl/pwm_multi.sv | 114 +++++++++++
 tb/tb_pwm_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator driven by one shared period counter.
//
// The counter runs either as a sawtooth (edge-aligned) or a triangle
// (center-aligned). Host duty writes land in a per-channel pending register.
// At the period boundary every pending value is attenuated by a logical
// right shift and loaded into the live duty register. The counting mode
// switches at the same boundary, so a period never changes shape part-way
// through.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   data_in      in   duty value to write                      [CNT_W]
//   ch_sel       in   target channel of the write              [CH_W]
//   valid_in     in   write strobe, always accepted
//   sh_amt       in   right shift applied at each boundary     [SH_W]
//   center_mode  in   0 = edge-aligned, 1 = center-aligned
//   sig_out      out  PWM outputs, bit i = channel i           [NUM_CH]
//   period_start out  high in the first cycle (cnt==0) of each period
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PERIOD = 255,
  parameter int SH_W   = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  data_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              valid_in,
  input  logic [SH_W-1:0]   sh_amt,
  input  logic              center_mode,
  output logic [NUM_CH-1:0] sig_out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_dir_dn;
  logic              r_mode;
  logic [CNT_W-1:0]  r_pend [NUM_CH];
  logic [CNT_W-1:0]  r_duty [NUM_CH];

  logic              w_bnd;
  logic              w_sel_ok;
  logic [NUM_CH-1:0] w_sig;

  // Logical right shift; any shift of the full width or more clears the value.
  function automatic logic [CNT_W-1:0] f_atten(input logic [CNT_W-1:0] v,
                                               input logic [SH_W-1:0]  s);
    if (int'(s) >= CNT_W) return '0;
    return v >> s;
  endfunction

  // Boundary = the cycle whose successor has cnt==0. In center mode with
  // PERIOD==1 the triangle degenerates to 0,1,0,... and the peak itself is
  // the last cycle, so the direction bit is not required there.
  always_comb begin
    if (r_mode)
      w_bnd = (r_cnt == LP_ONE) && (r_dir_dn || (PERIOD == 1));
    else
      w_bnd = (r_cnt == LP_PERIOD);
  end

  assign w_sel_ok = (int'(ch_sel) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dir_dn <= 1'b0;
      r_mode   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pend[i] <= '0;
        r_duty[i] <= '0;
      end
    end else begin
      if (w_bnd) begin
        r_cnt    <= '0;
        r_dir_dn <= 1'b0;
        r_mode   <= center_mode;
      end else if (r_mode && !r_dir_dn && (r_cnt == LP_PERIOD)) begin
        r_dir_dn <= 1'b1;
        r_cnt    <= r_cnt - 1'b1;
      end else if (r_dir_dn) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A write in the boundary cycle only reaches pend; duty takes the
      // value pend held before this edge.
      if (valid_in && w_sel_ok)
        r_pend[ch_sel] <= data_in;

      if (w_bnd) begin
        for (int i = 0; i < NUM_CH; i++)
          r_duty[i] <= f_atten(r_pend[i], sh_amt);
      end
    end
  end

  always_comb begin
    w_sig = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_sig[i] = !rst && (r_cnt < r_duty[i]);
  end

  assign sig_out      = w_sig;
  assign period_start = !rst && (r_cnt == '0);

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: two instances (PERIOD=255 with 4 channels, and
// PERIOD=10 with 3 channels). A negedge monitor measures each completed
// period (length and per-channel high time); expected measurements are
// queued when stimulus is driven and popped when the period completes.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic [1:0] ch_sel = '0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic [3:0] sh_amt = '0;
  logic       center_mode = 1'b0;
  logic [3:0] sig_a;
  logic [2:0] sig_b;
  logic       ps_a, ps_b;

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(4), .CNT_W(8), .PERIOD(255), .SH_W(4)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .ch_sel(ch_sel),
    .valid_in(valid_a), .sh_amt(sh_amt), .center_mode(center_mode),
    .sig_out(sig_a), .period_start(ps_a));

  pwm_multi #(.NUM_CH(3), .CNT_W(8), .PERIOD(10), .SH_W(4)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .ch_sel(ch_sel),
    .valid_in(valid_b), .sh_amt(sh_amt), .center_mode(center_mode),
    .sig_out(sig_b), .period_start(ps_b));

  int checks = 0;
  int errors = 0;

  // ---------------- period monitor ----------------
  logic [3:0] sig_m [2];
  logic [1:0] ps_m;
  assign sig_m[0] = sig_a;
  assign sig_m[1] = {1'b0, sig_b};
  assign ps_m     = {ps_b, ps_a};

  int acc_len [2] = '{0, 0};
  int acc_hi  [2][4];
  int last_len[2] = '{0, 0};
  int last_hi [2][4];
  int pdone   [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        acc_len[d] <= 0;
        for (int c = 0; c < 4; c++) acc_hi[d][c] <= 0;
      end else if (ps_m[d] && acc_len[d] > 0) begin
        last_len[d] <= acc_len[d];
        pdone[d]    <= pdone[d] + 1;
        acc_len[d]  <= 1;
        for (int c = 0; c < 4; c++) begin
          last_hi[d][c] <= acc_hi[d][c];
          acc_hi[d][c]  <= int'(sig_m[d][c]);
        end
      end else begin
        acc_len[d] <= acc_len[d] + 1;
        for (int c = 0; c < 4; c++) acc_hi[d][c] <= acc_hi[d][c] + int'(sig_m[d][c]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int    d;
    int    ch;
    int    hi;
    int    len;
    string name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int d; int ch; int data; int sh; int md; int hi; int len;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int ch, input int hi, input int len,
                          input string n);
    exp_t e;
    e.d = d; e.ch = ch; e.hi = hi; e.len = len; e.name = n;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_hi"}, last_hi[e.d][e.ch], e.hi);
    chk({e.name, "_len"}, last_len[e.d], e.len);
  endtask

  // Returns at posedge+1 just after instance d completed one period,
  // i.e. in the cnt==1 cycle of the new period.
  task automatic wait_period(input int d);
    int n0 = pdone[d];
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (pdone[d] == n0 && k < 1200);
    #1;
    if (pdone[d] == n0) chk("period_timeout", 0, 1);
  endtask

  // Called at posedge+1; one-cycle write strobe to instance d.
  task automatic write(input int d, input int ch, input int val, input int sh,
                       input int md);
    data_in     = 8'(val);
    ch_sel      = 2'(ch);
    sh_amt      = 4'(sh);
    center_mode = (md != 0);
    valid_a     = (d == 0);
    valid_b     = (d == 1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            d  ch data sh md  hi  len
    tbl[0]  = '{0, 0,  64, 0, 0,  64, 256};
    tbl[1]  = '{0, 1, 200, 2, 0,  50, 256};
    tbl[2]  = '{0, 1, 200, 9, 0,   0, 256};
    tbl[3]  = '{0, 3, 255, 0, 0, 255, 256};
    tbl[4]  = '{0, 2,   1, 0, 0,   1, 256};
    tbl[5]  = '{0, 0,  64, 0, 1, 127, 510};
    tbl[6]  = '{0, 3, 255, 0, 1, 509, 510};
    tbl[7]  = '{1, 2,   3, 0, 1,   5,  20};
    tbl[8]  = '{1, 2,  11, 0, 1,  20,  20};
    tbl[9]  = '{1, 2,   0, 0, 1,   0,  20};
    tbl[10] = '{1, 1,  12, 0, 0,  11,  11};
    tbl[11] = '{1, 1, 200, 5, 0,   6,  11};

    // Reset state and first cycle after release
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_sig_a", int'(sig_a), 0);
    chk("rst_ps_a", int'(ps_a), 0);
    chk("rst_sig_b", int'(sig_b), 0);
    chk("rst_ps_b", int'(ps_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("release_ps_a", int'(ps_a), 1);
    chk("release_ps_b", int'(ps_b), 1);

    // First write after reset: invisible for the rest of the first period
    @(posedge clk); #1;
    write(0, 0, 64, 0, 0);
    push_exp(0, 0, 0, 256, "first_period");
    wait_period(0);
    pop_check();
    push_exp(0, 0, 64, 256, "second_period");
    wait_period(0);
    pop_check();

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      wait_period(tbl[i].d);
      write(tbl[i].d, tbl[i].ch, tbl[i].data, tbl[i].sh, tbl[i].md);
      push_exp(tbl[i].d, tbl[i].ch, tbl[i].hi, tbl[i].len, $sformatf("vec%0d", i));
      wait_period(tbl[i].d);
      wait_period(tbl[i].d);
      pop_check();
    end

    // Mode toggle mid-period: current period keeps edge shape
    wait_period(1);
    write(1, 0, 5, 0, 0);
    wait_period(1);
    wait_period(1);
    repeat (3) begin @(posedge clk); #1; end
    center_mode = 1'b1;
    push_exp(1, 0, 5, 11, "toggle_keep");
    wait_period(1);
    pop_check();
    push_exp(1, 0, 9, 20, "toggle_new");
    wait_period(1);
    pop_check();

    // Write in the boundary-strobe cycle, then overwritten mid-period
    wait_period(0);
    write(0, 0, 40, 0, 0);
    wait_period(0);
    wait_period(0);
    repeat (254) begin @(posedge clk); #1; end
    write(0, 0, 100, 0, 0);
    wait_period(0);
    write(0, 0, 20, 0, 0);
    push_exp(0, 0, 40, 256, "bnd_write_old");
    wait_period(0);
    pop_check();
    push_exp(0, 0, 20, 256, "bnd_write_new");
    wait_period(0);
    pop_check();

    // Out-of-range channel select on the 3-channel instance
    wait_period(1);
    write(1, 3, 9, 0, 0);
    push_exp(1, 0, 5, 11, "bad_sel_ch0");
    push_exp(1, 1, 11, 11, "bad_sel_ch1");
    push_exp(1, 2, 0, 11, "bad_sel_ch2");
    wait_period(1);
    wait_period(1);
    pop_check();
    pop_check();
    pop_check();

    // One-cycle reset mid-period; a write in the reset cycle is dropped
    wait_period(0);
    repeat (20) begin @(posedge clk); #1; end
    rst     = 1'b1;
    data_in = 8'd77;
    ch_sel  = 2'd3;
    valid_a = 1'b1;
    @(negedge clk);
    chk("midrst_sig_a", int'(sig_a), 0);
    chk("midrst_ps_a", int'(ps_a), 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    valid_a = 1'b0;
    @(negedge clk);
    chk("midrst_release_ps_a", int'(ps_a), 1);
    chk("midrst_release_sig_a", int'(sig_a), 0);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) push_exp(0, c, 0, 256, $sformatf("after_rst_ch%0d", c));
    wait_period(0);
    wait_period(0);
    for (int c = 0; c < 4; c++) pop_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
